// File: rtl/lcell_circuit_tester.sv
// Exhaustive truth-table sequencer for a 4-in/1-out evolved LCELL netlist that may oscillate.
// Optional multi-sample instability detection is built when STABILITY_CHECK_EN is defined.
module lcell_circuit_tester #(
  parameter int unsigned IN_W       = 4,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned SAMPLES    = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [2**IN_W-1:0]   expected_i,
  output logic [IN_W-1:0]      cut_in_o,
  input  logic                 cut_out_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [2**IN_W-1:0]   mismatch_o,
  output logic [2**IN_W-1:0]   unstable_o
);

  localparam int unsigned NumVec = 2**IN_W;
  localparam logic [IN_W:0] LastVec = (IN_W+1)'(NumVec - 1);
  localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE_CYC - 1);
`ifdef STABILITY_CHECK_EN
  localparam logic [CNT_W-1:0] SampleLast = CNT_W'(SAMPLES - 1);
`else
  // Exactly one sample per vector when instability is not being measured.
  localparam logic [CNT_W-1:0] SampleLast = CNT_W'(SAMPLES / SAMPLES - 1);
`endif

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StSample,
    StEval,
    StDone
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [IN_W:0]       vec_q;
  logic [NumVec-1:0]   exp_q;
  logic [NumVec-1:0]   mismatch_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [1:0]          sync_q;
  logic                cut_sync;
  logic [IN_W-1:0]     vidx;

`ifdef STABILITY_CHECK_EN
  logic [NumVec-1:0]   unstable_q;
  logic                s0_q;
`endif

  assign cut_sync = sync_q[1];
  assign vidx     = vec_q[IN_W-1:0];

  // The CUT output is asynchronous and may oscillate; never sample it directly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], cut_out_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      vec_q      <= '0;
      exp_q      <= '0;
      mismatch_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
`ifdef STABILITY_CHECK_EN
      unstable_q <= '0;
      s0_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q    <= StSettle;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            vec_q      <= '0;
            exp_q      <= expected_i;
            mismatch_q <= '0;
            pass_q     <= 1'b0;
`ifdef STABILITY_CHECK_EN
            unstable_q <= '0;
`endif
          end
        end
        StSettle: begin
          if (cnt_q == SettleLast) begin
            cnt_q   <= '0;
            state_q <= StSample;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StSample: begin
          if (cut_sync != exp_q[vidx]) begin
            mismatch_q[vidx] <= 1'b1;
          end
`ifdef STABILITY_CHECK_EN
          // First sample is the reference every later sample must agree with.
          if (cnt_q == '0) begin
            s0_q <= cut_sync;
          end else if (cut_sync != s0_q) begin
            unstable_q[vidx] <= 1'b1;
          end
`endif
          if (cnt_q == SampleLast) begin
            cnt_q   <= '0;
            state_q <= StEval;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StEval: begin
          if (vec_q == LastVec) begin
            state_q <= StDone;
          end else begin
            vec_q   <= vec_q + 1'b1;
            state_q <= StSettle;
          end
        end
        StDone: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          pass_q  <= ~|mismatch_q & ~|unstable_o;
          vec_q   <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cut_in_o   = vec_q[IN_W-1:0];
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign pass_o     = pass_q;
  assign mismatch_o = mismatch_q;
`ifdef STABILITY_CHECK_EN
  assign unstable_o = unstable_q;
`else
  assign unstable_o = '0;
`endif

endmodule
